// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
//   - default geometry and reset configuration
//   - overlap-mode encoding
//   - LEN_W helper (bits needed to hold a length of 0..PAT_W)
package seq_det_pkg;

  localparam int          PAT_W_DEF       = 8;
  localparam logic [7:0]  RST_PATTERN_DEF = 8'b0000_0101;
  localparam int          RST_LEN_DEF     = 3;
  localparam int          CNT_W_DEF       = 16;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// History shift register plus saturating fill counter.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   shift_en    shift in_bit into hist (newest at bit 0) and advance fill
//   in_bit      bit to shift in
//   fill_clr    with shift_en: hist still shifts but fill restarts at 0
//   full_clr    clear hist and fill (takes priority over shifting)
//   hist        history bits
//   fill        number of valid history bits, saturating at PAT_W
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             shift_en,
  input  logic             in_bit,
  input  logic             fill_clr,
  input  logic             full_clr,
  output logic [PAT_W-1:0] hist,
  output logic [LEN_W-1:0] fill
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist <= '0;
      fill <= '0;
    end else if (full_clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= {hist[PAT_W-2:0], in_bit};
      if (fill_clr)
        fill <= '0;
      else if (fill != FILL_MAX)
        fill <= fill + LEN_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with runtime pattern, length and overlap mode.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in, in_vld           serial data bit and its qualifier
//   cfg_we               load cfg_pattern / cfg_len / cfg_ovl (drops this sample)
//   cfg_pattern          pattern, bit [len-1] is received first
//   cfg_len              length; 0 or > PAT_W selects PAT_W
//   cfg_ovl              1 = overlapping matches, 0 = non-overlapping
//   clr_cnt              clear match counter and saturation flag
//   out                  combinational (Mealy) match strobe
//   sync_out             out delayed by one cycle
//   match_cnt, cnt_sat   saturating match count and sticky saturation flag
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = PAT_W_DEF,
  parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(RST_PATTERN_DEF),
  parameter int               RST_LEN     = RST_LEN_DEF,
  parameter logic             RST_OVL     = OVL_ON,
  parameter int               CNT_W       = CNT_W_DEF,
  localparam int              LEN_W       = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in,
  input  logic             in_vld,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             clr_cnt,
  output logic             out,
  output logic             sync_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg;
  logic             ovl_reg;

  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;

  logic [PAT_W:0]   win_full;
  logic [PAT_W:0]   mask;
  logic             fill_ok;
  logic             bits_eq;
  logic [CNT_W-1:0] cnt_inc;

  // Configuration registers; out-of-range lengths select the full width.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat_reg <= RST_PATTERN;
      len_reg <= LEN_W'(RST_LEN);
      ovl_reg <= RST_OVL;
    end else if (cfg_we) begin
      pat_reg <= cfg_pattern;
      len_reg <= (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      ovl_reg <= cfg_ovl;
    end
  end

  seq_det_window #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_window (
    .clk      (clk),
    .rstn     (rstn),
    .shift_en (in_vld & ~cfg_we),
    .in_bit   (in),
    .fill_clr (out & (ovl_reg == OVL_OFF)),
    .full_clr (cfg_we),
    .hist     (hist),
    .fill     (fill)
  );

  // The whole history plus the live bit is compared, with bits at and above
  // len masked off; this avoids a variable-width part select.
  assign win_full = {hist, in};
  assign mask     = ~({(PAT_W+1){1'b1}} << len_reg);
  assign bits_eq  = ((win_full ^ {1'b0, pat_reg}) & mask) == '0;
  // len_reg is never 0, so len_reg-1 cannot wrap.
  assign fill_ok  = fill >= (len_reg - LEN_W'(1));
  assign out      = rstn & in_vld & ~cfg_we & fill_ok & bits_eq;

  assign cnt_inc  = match_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_out  <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      sync_out <= out;
      if (clr_cnt) begin
        match_cnt <= '0;
        cnt_sat   <= 1'b0;
      end else if (out && match_cnt != '1) begin
        match_cnt <= cnt_inc;
        if (cnt_inc == '1)
          cnt_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector.sv
module tb_seq_detector;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in = 1'b0, in_vld = 1'b0, cfg_we = 1'b0, cfg_ovl = 1'b0, clr_cnt = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       out, sync_out, cnt_sat, out2, sync_out2, cnt_sat2;
  logic [15:0] match_cnt;
  logic [1:0]  match_cnt2;

  always #5 clk = ~clk;

  seq_detector dut (
    .clk(clk), .rstn(rstn), .in(in), .in_vld(in_vld), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .clr_cnt(clr_cnt), .out(out), .sync_out(sync_out),
    .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .in(in), .in_vld(in_vld), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .clr_cnt(clr_cnt), .out(out2), .sync_out(sync_out2),
    .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  // ---------------- behavioural model ----------------
  // q holds the valid bits received since the last restart point (reset,
  // configuration load, or a non-overlapping match), oldest first.
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt16, m_cnt2;
  bit         m_sat16, m_sat2, m_sync;
  logic [31:0] seg;
  int n_cmp = 0, n_err = 0;

  task automatic model_reset();
    q.delete();
    m_pat = 8'b0000_0101; m_len = 3; m_ovl = 1'b1;
    m_cnt16 = 0; m_cnt2 = 0; m_sat16 = 0; m_sat2 = 0; m_sync = 0;
  endtask

  function automatic bit model_match(bit b, bit v, bit we);
    if (!v || we) return 1'b0;
    if (q.size() + 1 < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      bit w;
      w = (i == 0) ? b : q[q.size() - i];
      if (w != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_update(bit b, bit v, bit we, logic [7:0] pat, int len, bit ovl, bit clr, bit e);
    if (clr) begin
      m_cnt16 = 0; m_cnt2 = 0; m_sat16 = 0; m_sat2 = 0;
    end else if (e) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt16 == 65535) m_sat16 = 1;
      if (m_cnt2 < 3) m_cnt2++;
      if (m_cnt2 == 3) m_sat2 = 1;
    end
    m_sync = e;
    if (we) begin
      m_pat = pat; m_len = (len == 0 || len > 8) ? 8 : len; m_ovl = ovl;
      q.delete();
    end else if (v) begin
      if (e && !m_ovl) q.delete();
      else begin
        q.push_back(b);
        if (q.size() > 8) void'(q.pop_front());
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(bit e);
    chk("out", 32'(out), 32'(e));
    chk("out2", 32'(out2), 32'(e));
    chk("sync_out", 32'(sync_out), 32'(m_sync));
    chk("sync_out2", 32'(sync_out2), 32'(m_sync));
    chk("match_cnt", 32'(match_cnt), 32'(m_cnt16));
    chk("match_cnt2", 32'(match_cnt2), 32'(m_cnt2));
    chk("cnt_sat", 32'(cnt_sat), 32'(m_sat16));
    chk("cnt_sat2", 32'(cnt_sat2), 32'(m_sat2));
  endtask

  // One cycle: drive, compare at the falling edge, advance model to the edge.
  task automatic step(bit b, bit v, bit we, logic [7:0] pat, logic [3:0] len, bit ovl, bit clr);
    bit e;
    in = b; in_vld = v; cfg_we = we; cfg_pattern = pat; cfg_len = len; cfg_ovl = ovl; clr_cnt = clr;
    @(negedge clk);
    e = model_match(b, v, we);
    seg = {seg[30:0], e};
    check_all(e);
    model_update(b, v, we, pat, int'(len), ovl, clr, e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; in = 1'b1; in_vld = 1'b1; cfg_we = 1'b0; clr_cnt = 1'b0;
    model_reset();
    @(negedge clk);
    check_all(1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic send(bit b);
    step(b, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // Reset defaults: 101 overlapping
    seg = 0;
    send(1); send(0); send(1); send(0); send(1);
    chk("t1_out_seq", seg & 32'h1F, 32'b00101);
    send(0);
    chk("t1_cnt", 32'(match_cnt), 32'd2);
    $display("t1 defaults overlap: cnt=%0d", match_cnt);

    // Non-overlapping 101
    step(0, 1'b0, 1'b1, 8'b0000_0101, 4'd3, 1'b0, 1'b0);
    seg = 0;
    send(1); send(0); send(1); send(0); send(1);
    chk("t2_out_seq", seg & 32'h1F, 32'b00100);
    chk("t2_cnt", 32'(match_cnt), 32'd3);
    $display("t2 non-overlap: cnt=%0d", match_cnt);

    // Length 8, A5, gap of two idle cycles after bit 4
    step(0, 1'b0, 1'b1, 8'hA5, 4'd8, 1'b1, 1'b0);
    seg = 0;
    send(1); send(0); send(1); send(0);
    step(1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    send(0); send(1); send(0); send(1);
    chk("t3_out_seq", seg & 32'h3FF, 32'b0000000001);
    $display("t3 len8 gap: cnt=%0d", match_cnt);

    // Reset mid-pattern
    do_reset();
    send(1); send(0);
    do_reset();
    seg = 0;
    send(1);
    chk("t4_out_seq", seg & 32'h1, 32'd0);
    chk("t4_cnt", 32'(match_cnt), 32'd0);
    $display("t4 reset mid-pattern: cnt=%0d", match_cnt);

    // cfg_len = 0 -> 8, cfg_we collides with a would-be matching bit
    send(1); send(0);
    seg = 0;
    step(1, 1'b1, 1'b1, 8'hA5, 4'd0, 1'b1, 1'b0);
    chk("t5_we_out", seg & 32'h1, 32'd0);
    chk("t5_fill", 32'(dut.u_window.fill), 32'd0);
    seg = 0;
    for (int i = 7; i >= 0; i--) send(8'hA5 >> i);
    chk("t5_len8_seq", seg & 32'hFF, 32'b00000001);
    $display("t5 len0 clamp: cnt=%0d", match_cnt);

    // Saturation on the 2-bit counter instance
    do_reset();
    for (int i = 0; i < 9; i++) send(i % 2 == 0);
    send(0);
    chk("t6_cnt2", 32'(match_cnt2), 32'd3);
    chk("t6_sat2", 32'(cnt_sat2), 32'd1);
    step(1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    chk("t6_clr_cnt2", 32'(match_cnt2), 32'd0);
    chk("t6_clr_sat2", 32'(cnt_sat2), 32'd0);
    $display("t6 saturation: cnt2=%0d sat2=%0d", match_cnt2, cnt_sat2);

    // Randomized phase
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 2) do_reset();
      else if (r < 15)
        step($urandom_range(0,1), $urandom_range(0,1), 1'b1, 8'($urandom),
             4'($urandom_range(0, 9)), $urandom_range(0,1), 1'b0);
      else
        step($urandom_range(0,1), $urandom_range(0,3) != 0, 1'b0, 8'($urandom),
             4'($urandom), $urandom_range(0,1), $urandom_range(0,199) == 0);
    end
    $display("random phase done: cnt=%0d", match_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
